button_event: RTL

//  Consumer end of the debounced button line: takes the clean active-low IntBTN level

---
 rtl/button_event.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/button_event.sv
// Turns the debounced active-low IntBTN level into single-cycle button events.
// Optional double-click detection is compiled in with `define BTN_DCLICK_EN.
module button_event #(
  parameter int unsigned LONG_CYCLES   = 12_000_000,
  parameter int unsigned REPEAT_CYCLES = 2_400_000,
  parameter int unsigned DCLICK_CYCLES = 7_200_000
) (
  input  logic Fg_CLK,
  input  logic RESET,
  input  logic IntBTN,
  output logic PRESS_o,
  output logic RELEASE_o,
  output logic CLICK_o,
  output logic LONG_o,
  output logic REPEAT_o,
  output logic STEP_o,
  output logic HELD_o,
  output logic DCLICK_o
);

  localparam int unsigned MaxLr  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned MaxCyc = (MaxLr > DCLICK_CYCLES) ? MaxLr : DCLICK_CYCLES;
  localparam int unsigned CNT_W  = $clog2(MaxCyc) + 1;

  // Terminal values: a counter equal to these means the current sample completes the period.
  localparam logic [CNT_W-1:0] LongLast   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_CYCLES - 1);

`ifdef BTN_DCLICK_EN
  localparam logic [CNT_W-1:0] DclickLast = CNT_W'(DCLICK_CYCLES - 1);

  typedef enum logic [2:0] {StArmed, StIdle, StShort, StLong, StWait2} state_e;
`else
  typedef enum logic [2:0] {StArmed, StIdle, StShort, StLong} state_e;
`endif

  state_e           r_state;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] r_rep;
  logic             r_press;
  logic             r_release;
  logic             r_click;
  logic             r_long;
  logic             r_repeat;
  logic             r_step;
  logic             r_held;
`ifdef BTN_DCLICK_EN
  logic [CNT_W-1:0] r_win;
  logic             r_second;
  logic             r_dclick;
`endif

  always_ff @(posedge Fg_CLK) begin
    if (RESET) begin
      r_state   <= StArmed;
      r_hold    <= '0;
      r_rep     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_step    <= 1'b0;
      r_held    <= 1'b0;
`ifdef BTN_DCLICK_EN
      r_win     <= '0;
      r_second  <= 1'b0;
      r_dclick  <= 1'b0;
`endif
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_click   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_step    <= 1'b0;
`ifdef BTN_DCLICK_EN
      r_dclick  <= 1'b0;
`endif
      unique case (r_state)
        // A button held through reset must be released before it can generate events.
        StArmed: begin
          if (IntBTN) r_state <= StIdle;
        end
        StIdle: begin
          if (!IntBTN) begin
            r_state <= StShort;
            r_press <= 1'b1;
            r_step  <= 1'b1;
            r_hold  <= CNT_W'(1);
`ifdef BTN_DCLICK_EN
            r_second <= 1'b0;
`endif
          end
        end
        StShort: begin
          if (!IntBTN) begin
            if (r_hold == LongLast) begin
              r_state <= StLong;
              r_long  <= 1'b1;
              r_held  <= 1'b1;
              r_rep   <= '0;
            end else begin
              r_hold <= r_hold + CNT_W'(1);
            end
          end else begin
            r_release <= 1'b1;
`ifdef BTN_DCLICK_EN
            if (r_second) begin
              r_state <= StIdle;
            end else begin
              r_state <= StWait2;
              r_win   <= '0;
            end
`else
            r_click <= 1'b1;
            r_state <= StIdle;
`endif
          end
        end
        StLong: begin
          if (!IntBTN) begin
            if (r_rep == RepeatLast) begin
              r_rep    <= '0;
              r_repeat <= 1'b1;
              r_step   <= 1'b1;
            end else begin
              r_rep <= r_rep + CNT_W'(1);
            end
          end else begin
            r_release <= 1'b1;
            r_held    <= 1'b0;
            r_state   <= StIdle;
          end
        end
`ifdef BTN_DCLICK_EN
        // Window opens at the release sample; each later high sample consumes one slot.
        StWait2: begin
          if (!IntBTN) begin
            r_state  <= StShort;
            r_press  <= 1'b1;
            r_step   <= 1'b1;
            r_dclick <= 1'b1;
            r_second <= 1'b1;
            r_hold   <= CNT_W'(1);
          end else if (r_win == DclickLast) begin
            r_click <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_win <= r_win + CNT_W'(1);
          end
        end
`endif
        default: r_state <= StArmed;
      endcase
    end
  end

  assign PRESS_o   = r_press;
  assign RELEASE_o = r_release;
  assign CLICK_o   = r_click;
  assign LONG_o    = r_long;
  assign REPEAT_o  = r_repeat;
  assign STEP_o    = r_step;
  assign HELD_o    = r_held;
`ifdef BTN_DCLICK_EN
  assign DCLICK_o  = r_dclick;
`else
  assign DCLICK_o  = 1'b0;
`endif

endmodule
